operand_fetch: RTL
==================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 in_valid  input  1  upstream instruction valid.
REQ-004 in_ready  output  1  block can accept an instruction this cycle.
REQ-005 in_instr  input  32  instruction word; rs = [25:21], rt = [20:16].
REQ-006 raddr0  output  5  register-file read address, port 0; combinational = in_instr[25:21].
REQ-007 raddr1  output  5  register-file read address, port 1; combinational = in_instr[20:16].
REQ-008 rdata0  input  32  register-file read data, port 0, same cycle as raddr0.
REQ-009 rdata1  input  32  register-file read data, port 1, same cycle as raddr1.
REQ-010 wb_waddr  input  5  snooped register-file write address.
REQ-011 wb_wdata  input  32  snooped register-file write data.
REQ-012 wb_wren  input  1  snooped register-file write enable.
REQ-013 out_valid  output  1  operand bundle valid.
REQ-014 out_ready  input  1  downstream accepts bundle.
REQ-015 out_instr  output  32  registered copy of the accepted instruction.
REQ-016 out_op_a  output  32  operand for rs.
REQ-017 out_op_b  output  32  operand for rt.
REQ-018 stall_cnt  output  16  count of cycles with out_valid=1 and out_ready=0; saturates.

Function
REQ-019 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-020 in_ready SHALL = !out_valid || out_ready, combinational. The block has no stall states beyond this and has one output stage.
REQ-021 Latency: the bundle appears on out_* one cycle after the input transfer. Back-to-back accepts give one instruction per cycle.
REQ-022 Operand select at accept, per port, in priority order:
- address == 0 -> 0x00000000.
- else wb_wren && wb_waddr == address -> wb_wdata (same-cycle write bypass).
- else rdata.
REQ-023 Hold snoop: while out_valid && !out_ready, a cycle with wb_wren && wb_waddr == held rs (rs != 0) SHALL load wb_wdata into out_op_a. The same rule with held rt applies to out_op_b. Both operands can update in one cycle.
REQ-024 A write to register 0 SHALL never alter an operand.
REQ-025 An output transfer with no input transfer in the same cycle SHALL clear out_valid next cycle.
REQ-026 An output transfer with an input transfer in the same cycle SHALL load the new bundle and keep out_valid=1. A snoop aimed at the departing bundle is dropped.
REQ-027 While out_valid=0, out_* data SHALL hold its last value. Snoop does not apply.
REQ-028 stall_cnt SHALL increment by 1 per stall cycle and hold at 0xFFFF.
REQ-029 raddr0/raddr1 SHALL be driven from in_instr regardless of in_valid.

Reset
REQ-030 When rst=1 at a clock edge: out_valid=0, out_instr=0, out_op_a=0, out_op_b=0, stall_cnt=0.
REQ-031 rst SHALL take priority over any concurrent transfer or snoop. A held bundle is discarded.
REQ-032 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-033 Basic fetch: rf[3]=0x11, rf[4]=0x22; instr rs=3, rt=4, out_ready=1.
- Next cycle: out_valid=1, op_a=0x11, op_b=0x22.
REQ-034 Bypass: at accept of rs=5, wb_wren=1, waddr=5, wdata=0xDEAD, rdata0=stale.
- out_op_a=0xDEAD.
REQ-035 Zero register: rs=0, rt=0; wb_wren=1, waddr=0, wdata=0xFFFF_FFFF.
- op_a=op_b=0.
- The bundle is then held and a further waddr=0 write occurs: both operands stay 0.
REQ-036 Hold snoop: bundle rs=7 held with out_ready=0 for 3 cycles; wb write r7=0xBEEF in cycle 2.
- op_a=0xBEEF from cycle 3.
- stall_cnt=3.
- in_ready=0 throughout the hold.
REQ-037 Saturation: out_ready held 0 for 70000 cycles.
- stall_cnt=0xFFFF and stays there.
REQ-038 Reset mid-hold: rst=1 while a bundle is held.
- Next cycle: out_valid=0, stall_cnt=0, in_ready=1.

Source files
------------

// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
//   Single-stage operand fetch. Accepts an instruction, reads rs/rt from the
//   register file in the same cycle, and registers an operand bundle for the
//   next stage.
//
//   Operand selection when an instruction is accepted, highest priority first:
//     1. register 0 reads as zero;
//     2. a same-cycle writeback to the same register is bypassed;
//     3. otherwise the register-file read data is used.
//
//   While a bundle is stalled, writebacks to its source registers are snooped
//   so that the held operands never go stale.
//
//   Ports
//     clk, rst             clock; synchronous active-high reset
//     in_valid/in_ready    upstream handshake; in_instr = instruction word
//     raddr0/raddr1        combinational rs/rt read addresses
//     rdata0/rdata1        register-file read data (same cycle)
//     wb_waddr/wdata/wren  snooped register-file write port
//     out_valid/out_ready  downstream handshake
//     out_instr            registered copy of the accepted instruction
//     out_op_a/out_op_b    operands for rs/rt
//     stall_cnt            saturating count of out_valid && !out_ready cycles
// ---------------------------------------------------------------------------

// Per-port operand register: select at accept, snoop while held.
module of_operand_lane #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,      // input transfer this cycle
    input  logic          hold,      // bundle valid and stalled
    input  logic [AW-1:0] addr,      // address of the incoming instruction
    input  logic [DW-1:0] rdata,
    input  logic [AW-1:0] held_addr, // address of the held instruction
    input  logic          wb_wren,
    input  logic [AW-1:0] wb_waddr,
    input  logic [DW-1:0] wb_wdata,
    output logic [DW-1:0] op
);
    logic [DW-1:0] sel;
    logic          snoop_hit;

    always_comb begin
        if (addr == '0)
            sel = '0;
        else if (wb_wren && (wb_waddr == addr))
            sel = wb_wdata;
        else
            sel = rdata;
    end

    // Writes to r0 are ignored, so a held r0 operand stays zero.
    assign snoop_hit = hold && wb_wren && (held_addr != '0) && (wb_waddr == held_addr);

    // load and hold cannot both be true: in_ready is low whenever hold is high.
    always_ff @(posedge clk) begin
        if (rst)
            op <= '0;
        else if (load)
            op <= sel;
        else if (snoop_hit)
            op <= wb_wdata;
    end
endmodule

module operand_fetch #(
    parameter int NUM_PORTS = 2,
    parameter int AW        = 5,
    parameter int DW        = 32,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_instr,
    output logic [AW-1:0] raddr0,
    output logic [AW-1:0] raddr1,
    input  logic [DW-1:0] rdata0,
    input  logic [DW-1:0] rdata1,
    input  logic [AW-1:0] wb_waddr,
    input  logic [DW-1:0] wb_wdata,
    input  logic          wb_wren,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic [DW-1:0] out_op_a,
    output logic [DW-1:0] out_op_b,
    output logic [CW-1:0] stall_cnt
);
    logic                           in_xfer;
    logic                           out_xfer;
    logic                           hold;
    logic [NUM_PORTS-1:0][AW-1:0]   addr;
    logic [NUM_PORTS-1:0][AW-1:0]   held_addr;
    logic [NUM_PORTS-1:0][DW-1:0]   rdata;
    logic [NUM_PORTS-1:0][DW-1:0]   op;

    // Single output register: accept whenever it is empty or draining.
    assign in_ready = !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign hold     = out_valid && !out_ready;

    // Port 0 = rs [25:21], port 1 = rt [20:16]; both independent of in_valid.
    assign addr[0]      = in_instr[25:21];
    assign addr[1]      = in_instr[20:16];
    assign held_addr[0] = out_instr[25:21];
    assign held_addr[1] = out_instr[20:16];
    assign rdata[0]     = rdata0;
    assign rdata[1]     = rdata1;

    assign raddr0   = addr[0];
    assign raddr1   = addr[1];
    assign out_op_a = op[0];
    assign out_op_b = op[1];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
        of_operand_lane #(.AW(AW), .DW(DW)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .load      (in_xfer),
            .hold      (hold),
            .addr      (addr[p]),
            .rdata     (rdata[p]),
            .held_addr (held_addr[p]),
            .wb_wren   (wb_wren),
            .wb_waddr  (wb_waddr),
            .wb_wdata  (wb_wdata),
            .op        (op[p])
        );
    end

    // A simultaneous in/out transfer reloads the register and keeps it valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= '0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_instr <= in_instr;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (hold && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule
